// File: rtl/seq_alu.sv
// Multi-cycle ALU execute unit: single-cycle logic/arith/shift ops, Booth multiply, restoring divide.
// Define SEQ_ALU_MUL_RADIX4_EN to retire two multiplier bits per cycle (radix-4 Booth).
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int ACCW = WIDTH + 2;
    localparam int CNTW = $clog2(WIDTH) + 1;
`ifdef SEQ_ALU_MUL_RADIX4_EN
    localparam logic [CNTW-1:0] MUL_STEPS = CNTW'(WIDTH / 2);
`else
    localparam logic [CNTW-1:0] MUL_STEPS = CNTW'(WIDTH);
`endif
    localparam logic [CNTW-1:0] DIV_STEPS = CNTW'(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101, OP_AND2 = 5'b01101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_OR2  = 5'b01110;
    localparam logic [4:0] OP_SHR  = 5'b00111, OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001, OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011, OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DFIX, S_FIN} state_e;

    state_e            state_q;
    logic [CNTW-1:0]   cnt_q;
    logic              busy_q, done_q, dbz_q;
    logic [WIDTH-1:0]  hi_q, lo_q;
    // acc_q/shf_q hold the Booth partial product in MUL and remainder/quotient in DIV.
    logic [ACCW-1:0]   acc_q;
    logic [WIDTH-1:0]  shf_q, opb_q;
    logic              qm1_q, qneg_q, rneg_q;

    logic [SHW-1:0]    sh_amt;
    logic [SHW:0]      rol_amt;
    logic [WIDTH-1:0]  alu_lo, abs_a, abs_b;
    logic [ACCW-1:0]   m_ext, mul_sum, mul_acc_d, div_acc_d;
    logic [WIDTH-1:0]  mul_shf_d, div_shf_d;
    logic              mul_qm1_d;
    logic [WIDTH:0]    div_shl, div_dif;

    assign sh_amt  = b_in[SHW-1:0];
    assign rol_amt = (SHW+1)'(WIDTH) - {1'b0, sh_amt};
    assign abs_a   = a_in[WIDTH-1] ? -a_in : a_in;
    assign abs_b   = b_in[WIDTH-1] ? -b_in : b_in;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        alu_lo = '0;
        case (opcode)
            OP_ADD:          alu_lo = a_in + b_in;
            OP_SUB:          alu_lo = a_in - b_in;
            OP_AND, OP_AND2: alu_lo = a_in & b_in;
            OP_OR,  OP_OR2:  alu_lo = a_in | b_in;
            OP_SHR:          alu_lo = a_in >> sh_amt;
            OP_SHRA:         alu_lo = $signed(a_in) >>> sh_amt;
            OP_SHL:          alu_lo = a_in << sh_amt;
            OP_ROR:          alu_lo = WIDTH'({a_in, a_in} >> sh_amt);
            OP_ROL:          alu_lo = WIDTH'({a_in, a_in} >> rol_amt);
            OP_NEG:          alu_lo = -b_in;
            OP_NOT:          alu_lo = ~b_in;
            default:         alu_lo = '0;
        endcase
    end

    always_comb begin
        m_ext   = {{2{opb_q[WIDTH-1]}}, opb_q};
        mul_sum = acc_q;
`ifdef SEQ_ALU_MUL_RADIX4_EN
        case ({shf_q[1:0], qm1_q})
            3'b001, 3'b010: mul_sum = acc_q + m_ext;
            3'b011:         mul_sum = acc_q + (m_ext << 1);
            3'b100:         mul_sum = acc_q - (m_ext << 1);
            3'b101, 3'b110: mul_sum = acc_q - m_ext;
            default:        mul_sum = acc_q;
        endcase
        mul_acc_d = {{2{mul_sum[ACCW-1]}}, mul_sum[ACCW-1:2]};
        mul_shf_d = {mul_sum[1:0], shf_q[WIDTH-1:2]};
        mul_qm1_d = shf_q[1];
`else
        case ({shf_q[0], qm1_q})
            2'b01:   mul_sum = acc_q + m_ext;
            2'b10:   mul_sum = acc_q - m_ext;
            default: mul_sum = acc_q;
        endcase
        mul_acc_d = {mul_sum[ACCW-1], mul_sum[ACCW-1:1]};
        mul_shf_d = {mul_sum[0], shf_q[WIDTH-1:1]};
        mul_qm1_d = shf_q[0];
`endif
    end

    // Restoring step: a non-negative trial difference means the divisor fits.
    always_comb begin
        div_shl = {acc_q[WIDTH-1:0], shf_q[WIDTH-1]};
        div_dif = div_shl - {1'b0, opb_q};
        if (!div_dif[WIDTH]) begin
            div_acc_d = {1'b0, div_dif};
            div_shf_d = {shf_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_d = {1'b0, div_shl};
            div_shf_d = {shf_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            shf_q   <= '0;
            opb_q   <= '0;
            qm1_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments; later writes in this block override the default.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_FIN: begin
                    state_q <= S_IDLE;
                    if (start) begin
                        dbz_q <= 1'b0;
                        if (opcode == OP_MUL) begin
                            state_q <= S_MUL;
                            busy_q  <= 1'b1;
                            cnt_q   <= MUL_STEPS;
                            acc_q   <= '0;
                            shf_q   <= b_in;
                            qm1_q   <= 1'b0;
                            opb_q   <= a_in;
                        end else if (opcode == OP_DIV && b_in != '0) begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                            cnt_q   <= DIV_STEPS;
                            acc_q   <= '0;
                            shf_q   <= abs_a;
                            opb_q   <= abs_b;
                            qneg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            rneg_q  <= a_in[WIDTH-1];
                        end else if (opcode == OP_DIV) begin
                            done_q <= 1'b1;
                            dbz_q  <= 1'b1;
                            hi_q   <= a_in;
                            lo_q   <= '1;
                        end else begin
                            done_q <= 1'b1;
                            hi_q   <= '0;
                            lo_q   <= alu_lo;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_d;
                    shf_q <= mul_shf_d;
                    qm1_q <= mul_qm1_d;
                    cnt_q <= cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= mul_acc_d[WIDTH-1:0];
                        lo_q    <= mul_shf_d;
                    end
                end
                S_DIV: begin
                    acc_q <= div_acc_d;
                    shf_q <= div_shf_d;
                    cnt_q <= cnt_q - CNTW'(1);
                    if (cnt_q == CNTW'(1)) state_q <= S_DFIX;
                end
                S_DFIX: begin
                    state_q <= S_FIN;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    hi_q    <= rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    lo_q    <= qneg_q ? -shf_q : shf_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_hi   = hi_q;
    assign result_lo   = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: per-cycle comparison against a behavioural model,
// plus directed literal checks and randomized op streams.
module tb_seq_alu;

    localparam int W = 32;
`ifdef SEQ_ALU_MUL_RADIX4_EN
    localparam int MUL_LAT = W / 2 + 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 2;

    localparam logic [4:0] OP_ADD = 5'd3,  OP_SHRA = 5'd8, OP_ROL = 5'd11;
    localparam logic [4:0] OP_MUL = 5'd15, OP_DIV  = 5'd16;

    logic         clk, clear, start;
    logic [4:0]   opcode;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_hi, result_lo;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cmp_en = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .clear(clear), .start(start), .opcode(opcode),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        logic [7:0]   lat;
    } exp_t;

    // Expected outcome of one op, from plain arithmetic on the operands.
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   r;
        int     sh;
        longint pa, pb, prod, q, rm;
        r  = '0;
        r.lat = 8'd1;
        sh = int'(b[4:0]);
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        case (op)
            5'd3:        r.lo = a + b;
            5'd4:        r.lo = a - b;
            5'd5, 5'd13: r.lo = a & b;
            5'd6, 5'd14: r.lo = a | b;
            5'd7:        r.lo = a >> sh;
            5'd8:        r.lo = $signed(a) >>> sh;
            5'd9:        r.lo = a << sh;
            5'd10:       r.lo = (sh == 0) ? a : ((a >> sh) | (a << (W - sh)));
            5'd11:       r.lo = (sh == 0) ? a : ((a << sh) | (a >> (W - sh)));
            5'd17:       r.lo = -b;
            5'd18:       r.lo = ~b;
            5'd15: begin
                prod  = pa * pb;
                r.hi  = prod[2*W-1:W];
                r.lo  = prod[W-1:0];
                r.lat = 8'(MUL_LAT);
            end
            5'd16: begin
                if (b == '0) begin
                    r.dbz = 1'b1;
                    r.hi  = a;
                    r.lo  = '1;
                end else begin
                    q     = pa / pb;
                    rm    = pa % pb;
                    r.hi  = rm[W-1:0];
                    r.lo  = q[W-1:0];
                    r.lat = 8'(DIV_LAT);
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Cycle-level expectation of the outputs, driven by the same inputs the DUT sees.
    logic         exp_busy, exp_done, exp_dbz;
    logic [W-1:0] exp_hi, exp_lo;
    int           pend_cnt;
    exp_t         pend;

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            exp_busy <= 1'b0; exp_done <= 1'b0; exp_dbz <= 1'b0;
            exp_hi   <= '0;   exp_lo   <= '0;   pend_cnt <= 0;
            pend     <= '0;
        end else begin : model_step
            exp_t r;
            exp_done <= 1'b0;
            if (pend_cnt != 0) begin
                pend_cnt <= pend_cnt - 1;
                if (pend_cnt == 1) begin
                    exp_done <= 1'b1;
                    exp_busy <= 1'b0;
                    exp_hi   <= pend.hi;
                    exp_lo   <= pend.lo;
                    exp_dbz  <= pend.dbz;
                end
            end else if (start) begin
                r = model(opcode, a_in, b_in);
                exp_dbz <= 1'b0;
                if (r.lat == 8'd1) begin
                    exp_done <= 1'b1;
                    exp_hi   <= r.hi;
                    exp_lo   <= r.lo;
                    exp_dbz  <= r.dbz;
                end else begin
                    pend     <= r;
                    pend_cnt <= int'(r.lat) - 1;
                    exp_busy <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en)
            check($sformatf("cycle %0d outputs", cyc),
                  {busy, done, div_by_zero, result_hi, result_lo},
                  {exp_busy, exp_done, exp_dbz, exp_hi, exp_lo});
    end

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; opcode = op; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; opcode = 5'($urandom); a_in = $urandom; b_in = $urandom;
    endtask

    // Returns the cycle (1 = cycle after accept) in which done was seen, bounded by limit.
    task automatic wait_done(input int limit, output int n);
        n = 1;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat, input logic [W-1:0] hi,
                          input logic [W-1:0] lo, input logic dbz);
        int n;
        issue(op, a, b);
        wait_done(lat + 5, n);
        check({name, " latency"}, n, lat);
        check({name, " hi"}, result_hi, hi);
        check({name, " lo"}, result_lo, lo);
        check({name, " div_by_zero"}, div_by_zero, dbz);
        check({name, " busy at done"}, busy, 1'b0);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] op_pool [18] = '{5'd3, 5'd4, 5'd5, 5'd13, 5'd6, 5'd14, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd17, 5'd18, 5'd15, 5'd16, 5'd0, 5'd31, 5'd1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n, ndone, done_at;
        clear = 1'b0; start = 1'b0; opcode = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {busy, done, div_by_zero, result_hi, result_lo}, '0);
        cmp_en = 1;
        @(posedge clk); #2 clear = 1'b1;

        run_op("mul -3*7",   OP_MUL,  32'hFFFF_FFFD, 32'd7, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div -7/2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div 5/0",    OP_DIV,  32'd5,         32'd0, 1,       32'd5,         32'hFFFF_FFFF, 1'b1);
        run_op("shra",       OP_SHRA, 32'h8000_0000, 32'd4, 1,       32'd0,         32'hF800_0000, 1'b0);
        run_op("rol 33",     OP_ROL,  32'h8000_0001, 32'd33, 1,      32'd0,         32'h0000_0003, 1'b0);
        run_op("div MIN/-1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'd0, 32'h8000_0000, 1'b0);

        // An add pulsed while the multiply is busy must be ignored.
        issue(OP_MUL, 32'd1000, 32'hFFFF_FFFE);
        opcode = OP_ADD; a_in = 32'd11; b_in = 32'd22;
        n = 1; ndone = 0; done_at = 0;
        while (n < MUL_LAT + 10) begin
            if (done) begin ndone++; done_at = n; end
            @(negedge clk);
            n++;
            start = (n == 5);
        end
        start = 1'b0;
        check("mul under add pulse done count", ndone, 1);
        check("mul under add pulse latency", done_at, MUL_LAT);
        check("mul under add pulse hi", result_hi, 32'hFFFF_FFFF);
        check("mul under add pulse lo", result_lo, 32'hFFFF_F830);

        // Abort a divide in its tenth cycle.
        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        @(posedge clk); #2 clear = 1'b0;
        #1 check("outputs right after clear", {busy, done, div_by_zero, result_hi, result_lo}, '0);
        @(posedge clk); #2 clear = 1'b1;
        ndone = 0;
        repeat (DIV_LAT + 10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no done after abort", ndone, 0);
        run_op("add after abort", OP_ADD, 32'd2, 32'd3, 1, 32'd0, 32'd5, 1'b0);

        // Random stream; start may land while busy and inputs change every cycle.
        repeat (4000) begin
            @(negedge clk);
            start  = ($urandom_range(0, 3) == 0);
            opcode = ($urandom_range(0, 9) == 0) ? 5'($urandom) : op_pool[$urandom_range(0, 17)];
            a_in   = rnd_opnd();
            b_in   = rnd_opnd();
        end
        @(negedge clk);
        start = 1'b0;
        repeat (DIV_LAT + 5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle ALU execute unit.
- Single-cycle ops: logic, add/sub, shift, rotate. Iterative ops: signed multiply (Booth) and signed divide (restoring, on magnitudes).
- Sits between the register-file read latches and the Z/HI/LO write-back path.
- Control unit stalls on busy and writes back on done.

Parameters:
- WIDTH, 32: operand width; even, >= 8.
- SHW, $clog2(WIDTH): shift-amount bits taken from b_in[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  asynchronous, active-low reset
- start  input  1  op request; sampled only when busy=0
- opcode  input  5  op select, same encoding as CPU ISA
- a_in  input  WIDTH  operand A (dividend, multiplicand, shift source)
- b_in  input  WIDTH  operand B (divisor, multiplier, shift amount)
- busy  output  1  op in progress; start ignored while high
- done  output  1  one-cycle pulse; results valid from this cycle on
- result_hi  output  WIDTH  mul upper half / div remainder / else 0
- result_lo  output  WIDTH  mul lower half / div quotient / single-cycle result
- div_by_zero  output  1  set with done of a div whose b_in==0

Behaviour:
- Reset (clear=0, async): state IDLE; busy=0, done=0, result_hi=0, result_lo=0, div_by_zero=0, iteration counter=0.
- Operands and opcode latched at the accepting edge (start=1, busy=0). Later changes on the inputs have no effect on that op.
- Opcodes:
  - 00011 add: A+B, carry discarded.
  - 00100 sub: A-B.
  - 00101 / 01101 and.
  - 00110 / 01110 or.
  - 00111 shr: logical right shift.
  - 01000 shra: arithmetic right shift.
  - 01001 shl.
  - 01010 ror.
  - 01011 rol.
  - 10001 neg: -B.
  - 10010 not: ~B.
  - 01111 mul.
  - 10000 div.
  - Any other opcode: single-cycle; result_hi=result_lo=0.
- Shift/rotate amount is b_in[SHW-1:0]; an amount of 0 returns A unchanged.
- States: IDLE, MUL, DIV, DFIX, FIN.
  - IDLE: single-cycle op -> results registered at the accepting edge; done=1 in the next cycle; stay IDLE; busy stays 0.
  - IDLE: mul -> MUL, busy=1. div with B!=0 -> DIV, busy=1. div with B==0 -> single-cycle: div_by_zero=1, result_hi=A, result_lo=all ones.
  - MUL: one radix-2 Booth step per cycle, WIDTH cycles, then -> FIN.
  - DIV: one restoring step per cycle on |A|, |B|, WIDTH cycles, then -> DFIX.
  - DFIX: negate quotient if sign(A)^sign(B); remainder takes sign(A); -> FIN.
  - FIN: write result_hi/result_lo, done=1, busy=0 at the same edge; -> IDLE.
- Latency from accepting edge to done cycle:
  - single-cycle ops: 1
  - mul: WIDTH+1
  - div: WIDTH+2
- done is high exactly one cycle. Results hold until the next done.
- div_by_zero clears at the next accepting edge.
- start is accepted again in the cycle done is high; back-to-back ops are allowed.
- Overflow: mul gives the exact 2*WIDTH product. div of MIN/-1 gives quotient=MIN, remainder=0, no flag.
- clear asserted mid-op aborts the op. All outputs return to reset values and no done is issued.

Optional Feature:
- Macro SEQ_ALU_MUL_RADIX4_EN.
- Defined: MUL uses radix-4 Booth recoding, 2 bits per cycle; mul latency is WIDTH/2+1.
- Undefined: radix-2; mul latency WIDTH+1.
- Results are identical in both builds. Div and single-cycle ops are unaffected.

Test Plan:
- WIDTH=32, mul A=0xFFFFFFFD (-3), B=7 -> done 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB (17 cycles with the macro).
- div A=0xFFFFFFF9 (-7), B=2 -> done 34 cycles after accept; lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0.
- div A=5, B=0 -> done 1 cycle after accept; div_by_zero=1, hi=5, lo=0xFFFFFFFF.
- shra A=0x80000000, B=4 -> lo=0xF8000000; then rol A=0x80000001, B=33 -> lo=0x00000003; each done 1 cycle after accept, busy never high.
- Pulse start with add during MUL busy -> ignored; mul result correct; exactly one done.
- Assert clear at cycle 10 of a div -> busy=0, all outputs 0 immediately; no done follows; next add 2+3 -> lo=5.
